// File: rtl/param_counter_if.sv
// Handshake-free control/status bundle for param_counter.
// The master drives controls; the slave drives the count outputs.
interface param_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             sat;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] counter;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up_dn, sat, load, load_val,
        input  counter, tc, wrap
    );

    modport slave (
        input  en, up_dn, sat, load, load_val,
        output counter, tc, wrap
    );
endinterface

// File: rtl/param_counter.sv
// Up/down counter with prescaler, saturate/wrap modes and clamped load.
// Terminal count is combinational; wrap is a registered one-cycle pulse.
module param_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = 15,
    parameter int unsigned PRESCALE = 1
) (
    input  logic           clk,
    input  logic           reset,
    param_counter_if.slave bus
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] LP_ZERO = '0;
    localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1);
    localparam logic [PW-1:0]    LP_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]    LP_PONE = PW'(1);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [PW-1:0]    r_pre;
    logic [PW-1:0]    w_pre_nxt;
    logic             r_wrap;
    logic             w_wrap_nxt;
    logic             w_step;
    logic             w_top;
    logic             w_bot;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_top  = (r_cnt == LP_MAX);
    assign w_bot  = (r_cnt == LP_ZERO);
    assign w_step = bus.en && !bus.load && (r_pre == LP_LAST);

    // Out-of-range loads are clamped so the count never exceeds MAX_VAL
    assign w_load_clamped = (bus.load_val > LP_MAX) ? LP_MAX : bus.load_val;

    always_comb begin
        w_pre_nxt = r_pre;
        if (bus.load) begin
            w_pre_nxt = '0;
        end else if (bus.en) begin
            w_pre_nxt = w_step ? '0 : (r_pre + LP_PONE);
        end
    end

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_wrap_nxt = 1'b0;
        if (bus.load) begin
            w_cnt_nxt = w_load_clamped;
        end else if (w_step) begin
            if (bus.up_dn) begin
                if (!w_top) begin
                    w_cnt_nxt = r_cnt + LP_ONE;
                end else if (!bus.sat) begin
                    w_cnt_nxt  = LP_ZERO;
                    w_wrap_nxt = 1'b1;
                end
            end else begin
                if (!w_bot) begin
                    w_cnt_nxt = r_cnt - LP_ONE;
                end else if (!bus.sat) begin
                    w_cnt_nxt  = LP_MAX;
                    w_wrap_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_pre  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_pre  <= w_pre_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign bus.counter = r_cnt;
    assign bus.wrap    = r_wrap;
    assign bus.tc      = bus.up_dn ? w_top : w_bot;

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter bit width; legal range 1..32.
REQ-002 Parameter MAX_VAL, default 15, terminal count value; legal range 1..(2^WIDTH)-1.
REQ-003 Parameter PRESCALE, default 1, enabled cycles per count step; legal range 1..256.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-006 en  input  1  count enable; high allows prescaler and counter to advance.
REQ-007 up_dn  input  1  direction; 1 = count up, 0 = count down.
REQ-008 sat  input  1  mode; 1 = saturate at bounds, 0 = wrap modulo MAX_VAL+1.
REQ-009 load  input  1  synchronous parallel load strobe.
REQ-010 load_val  input  WIDTH  value loaded when load is high.
REQ-011 counter  output  WIDTH  registered count value.
REQ-012 tc  output  1  combinational terminal-count flag.
REQ-013 wrap  output  1  registered one-cycle pulse marking a wrap event.

Function
REQ-014 Per-edge priority SHALL be: reset low > load high > count step > hold.
REQ-015 Load SHALL set counter to load_val; if load_val > MAX_VAL, counter SHALL be set to MAX_VAL.
REQ-016 Load SHALL clear the prescaler to 0, and wrap SHALL be 0 on the following cycle.
REQ-017 Prescaler SHALL be an internal counter 0..PRESCALE-1 that increments only on edges with en=1 and load=0.
REQ-018 A count step SHALL occur on an edge where en=1, load=0, and the prescaler equals PRESCALE-1; the prescaler SHALL return to 0 on that edge.
REQ-019 With PRESCALE=1, every edge with en=1 and load=0 SHALL be a count step (latency: 1 clk to counter change).
REQ-020 With en=0, counter and prescaler SHALL hold.
REQ-021 Up step, counter < MAX_VAL: counter SHALL become counter+1.
REQ-022 Up step, counter = MAX_VAL, sat=0: counter SHALL become 0 and wrap SHALL be 1 on the next cycle.
REQ-023 Up step, counter = MAX_VAL, sat=1: counter SHALL hold at MAX_VAL with wrap=0.
REQ-024 Down step, counter > 0: counter SHALL become counter-1.
REQ-025 Down step, counter = 0, sat=0: counter SHALL become MAX_VAL and wrap SHALL be 1 on the next cycle.
REQ-026 Down step, counter = 0, sat=1: counter SHALL hold at 0 with wrap=0.
REQ-027 wrap SHALL be 0 on every cycle not immediately following a wrap event; consecutive wrap events (MAX_VAL=1, PRESCALE=1) SHALL hold wrap high on each such cycle.
REQ-028 tc SHALL be 1 iff (up_dn=1 and counter=MAX_VAL) or (up_dn=0 and counter=0), independent of en.
REQ-029 Changes to up_dn or sat SHALL take effect on the next count step; these changes SHALL NOT reset the prescaler.
REQ-030 All arithmetic SHALL be WIDTH bits with no carry out; counter SHALL never exceed MAX_VAL.

Reset
REQ-031 reset=0 at a rising edge SHALL set counter=0, prescaler=0, and wrap=0, overriding load and en.
REQ-032 Reset asserted mid-count SHALL take effect on that edge; the counter SHALL resume from 0 on the first edge with reset=1 and en=1 (subject to the prescaler).
REQ-033 Before the first active reset edge, output values SHALL be unspecified; the bench SHALL NOT check them.

Verification
REQ-034 Defaults, reset low 2 cycles, then en=1, up_dn=1, sat=0 for 17 cycles -> counter 0,1..15,0; wrap=1 for one cycle after 15->0; tc=1 while counter=15.
REQ-035 Defaults, counter=0, up_dn=0, sat=1, en=1 for 3 cycles -> counter stays 0, wrap stays 0, tc=1; switch to up_dn=1 -> counter 1, tc=0.
REQ-036 MAX_VAL=9, load=1 with load_val=12 -> counter=9; then down step sat=0 from 0 -> counter=9 with wrap pulse.
REQ-037 PRESCALE=3, en=1 for 9 cycles from 0 -> counter steps to 1, 2, 3 on edges 3, 6, 9; en dropped at prescaler=1 for 4 cycles -> no step, and the step arrives 2 enabled edges after en returns.
REQ-038 Counting at counter=7 with load=1, reset=0 on the same edge -> counter=0 (reset wins); next edge with load=1, load_val=5, en=1 -> counter=5, no increment.
